// File: rtl/alu_pkg.sv
// Shared opcode, width and flag definitions for the ALU op sequencer.
package alu_pkg;

  localparam int OPC_W      = 4;
  localparam int SHIFT_W    = 5;
  localparam int TAG_W      = 4;
  localparam int FLAGS_W    = 3;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_SIGN  = 0;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_ADD   = 4'd0;
  localparam opcode_t OP_SUB   = 4'd1;
  localparam opcode_t OP_MUL   = 4'd2;
  localparam opcode_t OP_MIN   = 4'd3;
  localparam opcode_t OP_SEQ   = 4'd4;
  localparam opcode_t OP_PASSB = 4'd5;
  localparam opcode_t OP_SRL   = 4'd6;
  localparam opcode_t OP_SRA   = 4'd7;
  localparam opcode_t OP_SNE   = 4'd8;
  localparam opcode_t OP_MAX   = 4'd9;
  localparam opcode_t OP_NOR   = 4'd10;

  // One stage of the issue-tracking pipe that shadows the external ALU.
  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    opcode_t            op;
  } trk_t;

  function automatic logic is_arith(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signals of the ALU op sequencer; the
// sequencer takes the slave view, its environment the master view.
interface alu_op_sequencer_if #(parameter int WIDTH = 16);
  import alu_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  opcode_t              req_opcode;
  logic [WIDTH-1:0]     req_a;
  logic [WIDTH-1:0]     req_b;
  logic [SHIFT_W-1:0]   req_shift;
  logic [TAG_W-1:0]     req_tag;

  opcode_t              alu_opcode;
  logic [WIDTH-1:0]     alu_input1;
  logic [WIDTH-1:0]     alu_input2;
  logic [SHIFT_W-1:0]   alu_shiftValue;
  logic [WIDTH-1:0]     alu_result;
  logic                 alu_carry;
  logic                 alu_zero;
  logic                 alu_sign;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH-1:0]     rsp_result;
  logic [FLAGS_W-1:0]   rsp_flags;
  logic [TAG_W-1:0]     rsp_tag;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_shift, req_tag,
    output req_ready,
    output alu_opcode, alu_input1, alu_input2, alu_shiftValue,
    input  alu_result, alu_carry, alu_zero, alu_sign,
    output rsp_valid, rsp_result, rsp_flags, rsp_tag,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, req_shift, req_tag,
    input  req_ready,
    input  alu_opcode, alu_input1, alu_input2, alu_shiftValue,
    output alu_result, alu_carry, alu_zero, alu_sign,
    input  rsp_valid, rsp_result, rsp_flags, rsp_tag,
    output rsp_ready
  );

endinterface

// File: rtl/alu_seq_fifo.sv
// Synchronous show-ahead response FIFO; head entry is visible on o_rdata
// whenever the FIFO is non-empty, and push+pop in one cycle keeps the count.
module alu_seq_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [DW-1:0]    i_wdata,
  input  logic             i_pop,
  output logic [DW-1:0]    o_rdata,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  assign w_pop  = i_pop && (r_count != CNT_W'(0));
  // A pop in the same cycle frees the slot being written when full.
  assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= DW'(0);
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == CNT_W'(0));
  assign o_count = r_count;

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues requests into an external ALU_LAT-cycle pipelined ALU and returns
// results in order through a credit-protected FIFO. ALU_SEQ_LOCAL_FLAGS_EN
// recomputes the response flags locally instead of passing the ALU's through.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ALU_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int USED_W  = $clog2(FIFO_DEPTH + ALU_LAT + 2) + 1;
  localparam int ENTRY_W = TAG_W + FLAGS_W + WIDTH;

  logic               w_accept;
  logic               w_capture;
  logic               w_pop;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_fifo_count;
  logic [USED_W-1:0]  w_used;
  logic [FLAGS_W-1:0] w_flags;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;

  logic               r_iss_valid;
  logic [TAG_W-1:0]   r_iss_tag;
  opcode_t            r_alu_opcode;
  logic [WIDTH-1:0]   r_alu_input1;
  logic [WIDTH-1:0]   r_alu_input2;
  logic [SHIFT_W-1:0] r_alu_shift;
  trk_t               r_trk [ALU_LAT];

  assign w_accept = bus.req_valid && bus.req_ready;

  // Every op between the issue register and the FIFO output holds a credit.
  always_comb begin
    w_used = USED_W'(w_fifo_count) + USED_W'(r_iss_valid);
    for (int i = 0; i < ALU_LAT; i++) w_used = w_used + USED_W'(r_trk[i].valid);
  end

  assign bus.req_ready = !rst && (w_used < USED_W'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst || !w_accept) begin
      r_iss_valid  <= 1'b0;
      r_iss_tag    <= TAG_W'(0);
      r_alu_opcode <= OP_PASSB;
      r_alu_input1 <= WIDTH'(0);
      r_alu_input2 <= WIDTH'(0);
      r_alu_shift  <= SHIFT_W'(0);
    end else begin
      r_iss_valid  <= 1'b1;
      r_iss_tag    <= bus.req_tag;
      r_alu_opcode <= bus.req_opcode;
      r_alu_input1 <= bus.req_a;
      r_alu_input2 <= bus.req_b;
      r_alu_shift  <= bus.req_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ALU_LAT; i++) r_trk[i] <= '0;
    end else begin
      r_trk[0] <= trk_t'{valid: r_iss_valid, tag: r_iss_tag, op: r_alu_opcode};
      for (int i = 1; i < ALU_LAT; i++) r_trk[i] <= r_trk[i-1];
    end
  end

  assign w_capture = r_trk[ALU_LAT-1].valid;

  always_comb begin
    w_flags = FLAGS_W'(0);
`ifdef ALU_SEQ_LOCAL_FLAGS_EN
    w_flags[FLAG_CARRY] = is_arith(r_trk[ALU_LAT-1].op) ? bus.alu_carry : 1'b0;
    w_flags[FLAG_ZERO]  = (bus.alu_result == WIDTH'(0));
    w_flags[FLAG_SIGN]  = bus.alu_result[WIDTH-1];
`else
    w_flags[FLAG_CARRY] = bus.alu_carry;
    w_flags[FLAG_ZERO]  = bus.alu_zero;
    w_flags[FLAG_SIGN]  = bus.alu_sign;
`endif
  end

  assign w_wdata = {r_trk[ALU_LAT-1].tag, w_flags, bus.alu_result};
  assign w_pop   = !w_fifo_empty && bus.rsp_ready;

  alu_seq_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_capture),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.alu_opcode     = r_alu_opcode;
  assign bus.alu_input1     = r_alu_input1;
  assign bus.alu_input2     = r_alu_input2;
  assign bus.alu_shiftValue = r_alu_shift;
  assign bus.rsp_valid      = !w_fifo_empty;
  assign {bus.rsp_tag, bus.rsp_flags, bus.rsp_result} = w_rdata;

endmodule
